// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port synchronous word memory behind a valid/ready request port.
// Supports byte-strobe writes, a configurable read latency, error responses for
// out-of-range addresses, and a hardware init sweep after reset or on clr.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   valid      request valid; accepted in IDLE when clr is low
//   wr_rd      1 = write, 0 = read
//   addr       word address, compared zero-extended against DEPTH
//   wdata      write data
//   wstrb      byte enables for wdata
//   clr        re-run the init sweep; only looked at in IDLE, beats valid
//   ready      high only in IDLE
//   rdata      read data, meaningful while resp_valid is high for a read
//   resp_valid one-cycle response pulse for every accepted request
//   resp_err   qualifies resp_valid, set for out-of-range addresses
//   busy       high while the init sweep runs
//
// state  | meaning
// INIT   | writing INIT_VAL to mem[ptr], ptr 0..DEPTH-1
// IDLE   | ready for a request or a clr
// WAIT   | read latency count-down (only when RD_LAT > 1)
// RESP   | one-cycle response
module memory_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LAT = 2,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  input  logic                  clr,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic                  busy
);

  localparam int NB = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  // WAIT lasts RD_LAT-1 cycles; the counter starts at RD_LAT-2 and exits on 0.
  localparam logic [2:0] RD_CNT = 3'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [2:0]            cnt;
  logic                  is_rd;
  logic                  err_q;
  logic [WIDTH-1:0]      cap;
  logic [WIDTH-1:0]      rdata_q;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  in_range;
  logic                  accept;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign accept   = (state == S_IDLE) && valid && !clr;
  assign rdata    = rdata_q;

  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state)
      S_INIT: begin
        busy = 1'b1;
        if (ptr == LAST) state_nx = S_IDLE;
      end
      S_IDLE: begin
        ready = 1'b1;
        if (clr) state_nx = S_INIT;
        else if (valid) state_nx = (wr_rd || RD_LAT == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 3'd0) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      ptr     <= '0;
      cnt     <= '0;
      is_rd   <= 1'b0;
      err_q   <= 1'b0;
      cap     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      // ptr sits at 0 outside INIT so every entry into INIT starts a fresh sweep.
      if (state == S_INIT) ptr <= ptr + 1'b1;
      else                 ptr <= '0;
      if (accept) begin
        is_rd <= !wr_rd;
        err_q <= !in_range;
        cnt   <= RD_CNT;
        cap   <= in_range ? mem[addr] : '0;
        if (!wr_rd && RD_LAT == 1) rdata_q <= in_range ? mem[addr] : '0;
      end
      if (state == S_WAIT) begin
        if (cnt != 3'd0)  cnt <= cnt - 3'd1;
        else if (is_rd)   rdata_q <= cap;
      end
    end
  end

  // Storage carries no reset; its contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[ptr] <= INIT_VAL;
    end else if (accept && wr_rd && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (wstrb[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_ctrl.sv
module tb_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        wr_rd = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wstrb = '0;
  logic        clr = 1'b0;

  logic        valid_a, valid_b, clr_a, clr_b;
  logic        ready_a, ready_b, resp_valid_a, resp_valid_b;
  logic        resp_err_a, resp_err_b, busy_a, busy_b;
  logic [15:0] rdata_a, rdata_b;
  logic        ready_m, resp_valid_m, resp_err_m, busy_m;
  logic [15:0] rdata_m;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign valid_a = valid & ~sel;
  assign valid_b = valid & sel;
  assign clr_a   = clr & ~sel;
  assign clr_b   = clr & sel;
  assign ready_m      = sel ? ready_b : ready_a;
  assign resp_valid_m = sel ? resp_valid_b : resp_valid_a;
  assign resp_err_m   = sel ? resp_err_b : resp_err_a;
  assign busy_m       = sel ? busy_b : busy_a;
  assign rdata_m      = sel ? rdata_b : rdata_a;

  memory_ctrl u_dut (
    .clk(clk), .rst(rst), .valid(valid_a), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .clr(clr_a), .ready(ready_a), .rdata(rdata_a),
    .resp_valid(resp_valid_a), .resp_err(resp_err_a), .busy(busy_a)
  );

  memory_ctrl #(.DEPTH(48)) u_d48 (
    .clk(clk), .rst(rst), .valid(valid_b), .wr_rd(wr_rd), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .clr(clr_b), .ready(ready_b), .rdata(rdata_b),
    .resp_valid(resp_valid_b), .resp_err(resp_err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic ok,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (ok !== 1'b1) begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the selected instance and waits for its response.
  // lat counts samples after the accept edge up to and including resp_valid.
  task automatic req(input logic w, input logic [5:0] a, input logic [15:0] d,
                     input logic [1:0] s, output logic [15:0] rd,
                     output logic er, output int lat, output logic rdy);
    int n;
    n = 0;
    while (!ready_m && n < 200) begin
      step();
      n++;
    end
    chk("req_ready_wait", ready_m === 1'b1, ready_m, 1'b1);
    valid = 1'b1;
    wr_rd = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    step();
    valid = 1'b0;
    addr  = ~a;
    wdata = ~d;
    lat = 1;
    while (!resp_valid_m && lat < 20) begin
      step();
      lat++;
    end
    rd  = rdata_m;
    er  = resp_err_m;
    rdy = ready_m;
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] rd;
    logic        er, rdy;
    int          lat, na, nb, acc, rsp;

    // Reset values while rst is held low.
    #12;
    chk("rst_ready", ready_a === 1'b0, ready_a, 1'b0);
    chk("rst_resp_valid", resp_valid_a === 1'b0, resp_valid_a, 1'b0);
    chk("rst_resp_err", resp_err_a === 1'b0, resp_err_a, 1'b0);
    chk("rst_rdata", rdata_a === 16'h0000, rdata_a, 16'h0000);
    chk("rst_busy", busy_a === 1'b1, busy_a, 1'b1);

    // Sweep lengths: 64 for the default instance, 48 for the small one.
    step();
    rst = 1'b1;
    na = 0;
    nb = 0;
    for (int i = 0; i < 200 && (busy_a || busy_b); i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      chk("init_ready_low", ready_a === ~busy_a, ready_a, ~busy_a);
      step();
    end
    chk("init_len_64", na == 64, na, 64);
    chk("init_len_48", nb == 48, nb, 48);
    chk("post_init_ready", ready_a === 1'b1, ready_a, 1'b1);

    req(1'b0, 6'd7, 16'h0, 2'b11, rd, er, lat, rdy);
    chk("init_read_data", rd === 16'h0000, rd, 16'h0000);
    chk("init_read_lat", lat == 2, lat, 2);

    // Byte-strobe writes.
    req(1'b1, 6'd5, 16'hABCD, 2'b11, rd, er, lat, rdy);
    chk("wr_lat", lat == 1, lat, 1);
    chk("wr_err", er === 1'b0, er, 1'b0);
    req(1'b1, 6'd5, 16'h1234, 2'b01, rd, er, lat, rdy);
    req(1'b0, 6'd5, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("strobe_read", rd === 16'hAB34, rd, 16'hAB34);
    chk("strobe_read_lat", lat == 2, lat, 2);
    req(1'b1, 6'd5, 16'h0000, 2'b00, rd, er, lat, rdy);
    req(1'b0, 6'd5, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("nostrobe_read", rd === 16'hAB34, rd, 16'hAB34);
    req(1'b1, 6'd6, 16'h00FF, 2'b10, rd, er, lat, rdy);
    req(1'b0, 6'd6, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("hi_strobe_read", rd === 16'h0000, rd, 16'h0000);

    // Write timing and throughput.
    req(1'b1, 6'd9, 16'h0909, 2'b11, rd, er, lat, rdy);
    chk("wr_resp_ready_low", rdy === 1'b0, rdy, 1'b0);
    step();
    chk("wr_resp_one_cycle", resp_valid_a === 1'b0, resp_valid_a, 1'b0);
    chk("wr_ready_t2", ready_a === 1'b1, ready_a, 1'b1);
    valid = 1'b1;
    wr_rd = 1'b1;
    addr  = 6'd9;
    wdata = 16'h0A0A;
    wstrb = 2'b11;
    acc = 0;
    rsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready_a) acc++;
      step();
      if (resp_valid_a) rsp++;
    end
    valid = 1'b0;
    chk("b2b_accepts", acc == 4, acc, 4);
    chk("b2b_resps", rsp == 4, rsp, 4);

    // Out-of-range handling on the DEPTH=48 instance.
    sel = 1'b1;
    req(1'b1, 6'd2, 16'h5555, 2'b11, rd, er, lat, rdy);
    chk("d48_wr_ok_err", er === 1'b0, er, 1'b0);
    req(1'b1, 6'd50, 16'hFFFF, 2'b11, rd, er, lat, rdy);
    chk("d48_oor_wr_err", er === 1'b1, er, 1'b1);
    chk("d48_oor_wr_lat", lat == 1, lat, 1);
    req(1'b0, 6'd2, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("d48_no_alias", rd === 16'h5555, rd, 16'h5555);
    req(1'b0, 6'd50, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("d48_oor_rd_err", er === 1'b1, er, 1'b1);
    chk("d48_oor_rd_data", rd === 16'h0000, rd, 16'h0000);
    chk("d48_oor_rd_lat", lat == 2, lat, 2);
    req(1'b0, 6'd48, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("d48_edge_err", er === 1'b1, er, 1'b1);
    req(1'b0, 6'd47, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("d48_last_err", er === 1'b0, er, 1'b0);
    chk("d48_last_data", rd === 16'h0000, rd, 16'h0000);
    sel = 1'b0;

    // clr beats valid in IDLE and re-runs the sweep.
    step();
    clr   = 1'b1;
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = 6'd5;
    step();
    clr   = 1'b0;
    valid = 1'b0;
    na  = 0;
    rsp = 0;
    while (busy_a && na < 200) begin
      na++;
      if (resp_valid_a) rsp++;
      step();
    end
    chk("clr_sweep_len", na == 64, na, 64);
    chk("clr_no_resp", rsp == 0, rsp, 0);
    req(1'b0, 6'd5, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("clr_read_init", rd === 16'h0000, rd, 16'h0000);

    // Reset during WAIT of a read.
    req(1'b1, 6'd5, 16'h7777, 2'b11, rd, er, lat, rdy);
    req(1'b0, 6'd5, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("pre_rst_read", rd === 16'h7777, rd, 16'h7777);
    step();
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = 6'd5;
    step();
    valid = 1'b0;
    chk("in_wait_ready", ready_a === 1'b0, ready_a, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", ready_a === 1'b0, ready_a, 1'b0);
    chk("mid_rst_resp_valid", resp_valid_a === 1'b0, resp_valid_a, 1'b0);
    chk("mid_rst_rdata", rdata_a === 16'h0000, rdata_a, 16'h0000);
    chk("mid_rst_busy", busy_a === 1'b1, busy_a, 1'b1);
    rsp = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (resp_valid_a) rsp++;
    end
    rst = 1'b1;
    na = 0;
    while (busy_a && na < 200) begin
      na++;
      if (resp_valid_a) rsp++;
      step();
    end
    chk("mid_rst_no_resp", rsp == 0, rsp, 0);
    chk("mid_rst_sweep_len", na == 64, na, 64);
    req(1'b0, 6'd5, 16'h0, 2'b00, rd, er, lat, rdy);
    chk("mid_rst_read_init", rd === 16'h0000, rd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
